// File: rtl/lock_pkg.sv
// Shared definitions for the digital lock: status bus encodings (also used by
// the 7-segment status decoder), FSM state encoding and the keypad digit width.
package lock_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [1:0] STATUS_INIT     = 2'b00;
  localparam logic [1:0] STATUS_LOCKED   = 2'b01;
  localparam logic [1:0] STATUS_UNLOCKED = 2'b10;
  localparam logic [1:0] STATUS_BLANK    = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT     = 2'b00,
    ST_LOCKED   = 2'b01,
    ST_UNLOCKED = 2'b10,
    ST_LOCKOUT  = 2'b11
  } lock_state_e;

  function automatic logic [1:0] state_status(input lock_state_e st);
    logic [1:0] s;
    case (st)
      ST_INIT:     s = STATUS_INIT;
      ST_LOCKED:   s = STATUS_LOCKED;
      ST_UNLOCKED: s = STATUS_UNLOCKED;
      ST_LOCKOUT:  s = STATUS_BLANK;
      default:     s = STATUS_INIT;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lock_entry_buffer.sv
// Keypad entry buffer: shifts digits in at the LSB nibble, saturates at
// CODE_DIGITS (extra digits are dropped) and empties on flush.
module lock_entry_buffer
  import lock_pkg::*;
#(
  parameter int CODE_DIGITS = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [DIGIT_W-1:0]                   digit_i,
  input  logic                                 shift_i,
  input  logic                                 flush_i,
  output logic [CODE_DIGITS*DIGIT_W-1:0]       shreg_o,
  output logic [$clog2(CODE_DIGITS+1)-1:0]     count_o,
  output logic                                 full_o
);

  localparam int BUF_W = CODE_DIGITS * DIGIT_W;
  localparam int CNT_W = $clog2(CODE_DIGITS + 1);

  logic [BUF_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_s;

  assign full_s = (count_q == CNT_W'(CODE_DIGITS));

  // Next-state for the shift register and fill count; flush wins over shift.
  always_comb begin
    shreg_d = shreg_q;
    count_d = count_q;
    if (flush_i) begin
      shreg_d = '0;
      count_d = '0;
    end else if (shift_i && !full_s) begin
      shreg_d = (shreg_q << DIGIT_W) | BUF_W'(digit_i);
      count_d = count_q + CNT_W'(1);
    end else begin
      shreg_d = shreg_q;
      count_d = count_q;
    end
  end

  // Buffer and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      count_q <= '0;
    end else begin
      shreg_q <= shreg_d;
      count_q <= count_d;
    end
  end

  assign shreg_o = shreg_q;
  assign count_o = count_q;
  assign full_o  = full_s;

endmodule

// File: rtl/lock_controller.sv
// Digital lock sequencer: stores a user code, compares entries against it,
// enforces a retry limit with a timed lockout and drives the status bus.
module lock_controller
  import lock_pkg::*;
#(
  parameter int CODE_DIGITS    = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 100000000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [3:0]                         digit,
  input  logic                               digit_valid,
  input  logic                               enter,
  input  logic                               clear,
  output logic [1:0]                         status,
  output logic [$clog2(CODE_DIGITS+1)-1:0]   entry_count,
  output logic [$clog2(MAX_TRIES+1)-1:0]     fail_count
);

  localparam int BUF_W  = CODE_DIGITS * DIGIT_W;
  localparam int CNT_W  = $clog2(CODE_DIGITS + 1);
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

  lock_state_e       state_q, state_d;
  logic [BUF_W-1:0]  code_q, code_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [1:0]        status_q, status_d;

  logic [BUF_W-1:0]  entry_s;
  logic [CNT_W-1:0]  count_s;
  logic              full_s;
  logic              flush_s;
  logic              shift_s;
  logic              commit_s;
  logic              match_s;
  logic [FAIL_W-1:0] fail_inc_s;

  lock_entry_buffer #(
    .CODE_DIGITS (CODE_DIGITS)
  ) u_entry (
    .clk     (clk),
    .reset   (reset),
    .digit_i (digit),
    .shift_i (shift_s),
    .flush_i (flush_s),
    .shreg_o (entry_s),
    .count_o (count_s),
    .full_o  (full_s)
  );

  assign match_s    = full_s && (entry_s == code_q);
  assign fail_inc_s = fail_q + FAIL_W'(1);

  // Pulse decode: clear > enter > digit_valid, all ignored during lockout.
  always_comb begin
    flush_s  = 1'b0;
    shift_s  = 1'b0;
    commit_s = 1'b0;
    if (state_q == ST_LOCKOUT) begin
      flush_s  = 1'b0;
      shift_s  = 1'b0;
      commit_s = 1'b0;
    end else if (clear) begin
      flush_s  = 1'b1;
    end else if (enter) begin
      flush_s  = 1'b1;
      commit_s = 1'b1;
    end else begin
      shift_s  = digit_valid;
    end
  end

  // FSM next-state, stored code, failure count and lockout timer.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    fail_d     = fail_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (commit_s && full_s) begin
          code_d  = entry_s;
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_LOCKED: begin
        if (commit_s && match_s) begin
          fail_d  = '0;
          state_d = ST_UNLOCKED;
        end else if (commit_s) begin
          fail_d = fail_inc_s;
          if (fail_inc_s == FAIL_W'(MAX_TRIES)) begin
            lock_cnt_d = LOCK_W'(LOCKOUT_CYCLES - 1);
            state_d    = ST_LOCKOUT;
          end else begin
            state_d = ST_LOCKED;
          end
        end else begin
          state_d = ST_LOCKED;
        end
      end
      ST_UNLOCKED: begin
        if (commit_s && (count_s == CNT_W'(0))) begin
          state_d = ST_LOCKED;
        end else if (commit_s && full_s) begin
          code_d  = entry_s;
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_UNLOCKED;
        end
      end
      ST_LOCKOUT: begin
        if (lock_cnt_q == LOCK_W'(0)) begin
          fail_d  = '0;
          state_d = ST_LOCKED;
        end else begin
          lock_cnt_d = lock_cnt_q - LOCK_W'(1);
          state_d    = ST_LOCKOUT;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
    status_d = state_status(state_d);
  end

  // Control registers; status is registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      code_q     <= '0;
      fail_q     <= '0;
      lock_cnt_q <= '0;
      status_q   <= STATUS_INIT;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      fail_q     <= fail_d;
      lock_cnt_q <= lock_cnt_d;
      status_q   <= status_d;
    end
  end

  assign status      = status_q;
  assign entry_count = count_s;
  assign fail_count  = fail_q;

endmodule

// File: tb/tb_lock_controller.sv
// Directed bench for lock_controller with a short lockout so the full
// lockout window can be counted cycle by cycle.
module tb_lock_controller;

  localparam int LOCK_CYC = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] digit = 4'd0;
  logic       digit_valid = 1'b0;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] status;
  logic [2:0] entry_count;
  logic [1:0] fail_count;

  int compared = 0;
  int mismatched = 0;
  int n_blank;
  int guard;

  lock_controller #(
    .CODE_DIGITS    (4),
    .MAX_TRIES      (3),
    .LOCKOUT_CYCLES (LOCK_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digit       (digit),
    .digit_valid (digit_valid),
    .enter       (enter),
    .clear       (clear),
    .status      (status),
    .entry_count (entry_count),
    .fail_count  (fail_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of pulses; returns #1 after the edge that samples them.
  task automatic pulse(input logic [3:0] d, input logic dv, input logic en, input logic cl);
    digit = d;
    digit_valid = dv;
    enter = en;
    clear = cl;
    @(posedge clk);
    #1;
    digit_valid = 1'b0;
    enter = 1'b0;
    clear = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    pulse(d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic press_enter();
    pulse(4'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic code4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    key(a); key(b); key(c); key(d);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_status", status, 2'b00);
    chk("reset_entry", entry_count, 3'd0);
    chk("reset_fail", fail_count, 2'd0);

    // Set code 1234 in INIT
    key(4'd1);
    chk("entry_after_1", entry_count, 3'd1);
    key(4'd2); key(4'd3); key(4'd4);
    chk("entry_full", entry_count, 3'd4);
    chk("init_before_enter", status, 2'b00);
    press_enter();
    chk("set_code_status", status, 2'b01);
    chk("set_code_entry", entry_count, 3'd0);

    // Unlock, then relock with bare enter
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    press_enter();
    chk("unlock_status", status, 2'b10);
    chk("unlock_fail", fail_count, 2'd0);
    press_enter();
    chk("relock_status", status, 2'b01);

    // Three wrong entries -> lockout
    code4(4'd9, 4'd9, 4'd9, 4'd9);
    press_enter();
    chk("wrong1_fail", fail_count, 2'd1);
    chk("wrong1_status", status, 2'b01);
    code4(4'd9, 4'd9, 4'd9, 4'd9);
    press_enter();
    chk("wrong2_fail", fail_count, 2'd2);
    code4(4'd9, 4'd9, 4'd9, 4'd9);
    press_enter();
    chk("lockout_status", status, 2'b11);
    chk("lockout_fail", fail_count, 2'd3);
    n_blank = 1;
    key(4'd5);
    if (status == 2'b11) n_blank++;
    chk("lockout_digit_ignored", entry_count, 3'd0);
    press_enter();
    if (status == 2'b11) n_blank++;
    pulse(4'd0, 1'b0, 1'b0, 1'b1);
    if (status == 2'b11) n_blank++;
    guard = 0;
    while (status == 2'b11 && guard < 64) begin
      @(posedge clk);
      #1;
      if (status == 2'b11) n_blank++;
      guard++;
    end
    chk("lockout_cycles", n_blank, LOCK_CYC);
    chk("post_lockout_status", status, 2'b01);
    chk("post_lockout_fail", fail_count, 2'd0);
    chk("post_lockout_entry", entry_count, 3'd0);

    // Saturation: fifth digit dropped, still unlocks
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    key(4'd5);
    chk("saturate_entry", entry_count, 3'd4);
    press_enter();
    chk("saturate_unlock", status, 2'b10);
    press_enter();
    chk("relock2_status", status, 2'b01);

    // clear alone
    key(4'd1); key(4'd2);
    pulse(4'd0, 1'b0, 1'b0, 1'b1);
    chk("clear_entry", entry_count, 3'd0);
    chk("clear_status", status, 2'b01);

    // clear + enter with full correct entry after one failure
    code4(4'd9, 4'd9, 4'd9, 4'd9);
    press_enter();
    chk("pre_clr_fail", fail_count, 2'd1);
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    pulse(4'd0, 1'b0, 1'b1, 1'b1);
    chk("clr_enter_status", status, 2'b01);
    chk("clr_enter_fail", fail_count, 2'd1);
    chk("clr_enter_entry", entry_count, 3'd0);

    // enter + digit_valid: digit dropped, short entry counts as failure
    key(4'd1); key(4'd2); key(4'd3);
    pulse(4'd4, 1'b1, 1'b1, 1'b0);
    chk("enter_digit_entry", entry_count, 3'd0);
    chk("enter_digit_fail", fail_count, 2'd2);
    chk("enter_digit_status", status, 2'b01);
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    press_enter();
    chk("unlock3_status", status, 2'b10);
    chk("unlock3_fail", fail_count, 2'd0);
    press_enter();

    // Reset in the middle of lockout
    repeat (3) begin
      code4(4'd9, 4'd9, 4'd9, 4'd9);
      press_enter();
    end
    chk("lockout2_status", status, 2'b11);
    repeat (3) @(posedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midreset_status", status, 2'b00);
    chk("midreset_fail", fail_count, 2'd0);
    chk("midreset_entry", entry_count, 3'd0);
    key(4'd1); key(4'd2);
    press_enter();
    chk("short_init_status", status, 2'b00);
    chk("short_init_entry", entry_count, 3'd0);

    // New code 5678; old code 1234 no longer accepted
    code4(4'd5, 4'd6, 4'd7, 4'd8);
    press_enter();
    chk("newcode_status", status, 2'b01);
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    press_enter();
    chk("oldcode_rejected", fail_count, 2'd1);
    code4(4'd5, 4'd6, 4'd7, 4'd8);
    press_enter();
    chk("newcode_unlock", status, 2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
